// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: memory address/data, redirect and stall controls, and the IR handshake toward decode.
// With IFU_PERF_COUNTERS_EN defined, the bus also carries the Fetch_Count and Stall_Count outputs.
interface instruction_fetch_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Stall;
   logic                  Redirect_Valid;
   logic [11:0]           Redirect_Target;
   logic [DATA_WIDTH-1:0] Address;
   logic [DATA_WIDTH-1:0] Mem_Instruction;
   logic [DATA_WIDTH-1:0] IR;
   logic [DATA_WIDTH-1:0] IR_PC;
   logic                  IR_Valid;
   logic                  IR_Ready;
   logic                  Halted;
`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0]           Fetch_Count;
   logic [31:0]           Stall_Count;
`endif

   modport master (
      input  Stall, Redirect_Valid, Redirect_Target, Mem_Instruction, IR_Ready,
      output Address, IR, IR_PC, IR_Valid, Halted
`ifdef IFU_PERF_COUNTERS_EN
      , output Fetch_Count, Stall_Count
`endif
   );

   modport slave (
      output Stall, Redirect_Valid, Redirect_Target, Mem_Instruction, IR_Ready,
      input  Address, IR, IR_PC, IR_Valid, Halted
`ifdef IFU_PERF_COUNTERS_EN
      , input Fetch_Count, Stall_Count
`endif
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, zero-latency memory address, single-entry IR with valid/ready, redirect/flush, sticky HALT.
// Optional macro IFU_PERF_COUNTERS_EN adds saturating fetch and stall counters.
module instruction_fetch_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int RESET_PC   = 0
) (
   input logic                      clk,
   input logic                      rst,
   instruction_fetch_unit_if.master bus
);
   localparam logic [DATA_WIDTH-1:0] PC_LIMIT    = DATA_WIDTH'(MEM_DEPTH * 4);
   localparam logic [DATA_WIDTH-1:0] PC_RESET    = DATA_WIDTH'(RESET_PC);
   localparam logic [4:0]            HALT_OPCODE = 5'b11111;

   typedef enum logic {RUN, HALTED} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_p0, pc_d;
   logic [DATA_WIDTH-1:0] ir_p1, ir_d;
   logic [DATA_WIDTH-1:0] ir_pc_p1, ir_pc_d;
   logic                  vld_p1, vld_d;
   logic                  free, fetch, redirect, is_halt;

   function automatic logic [DATA_WIDTH-1:0] wrap_inc(input logic [DATA_WIDTH-1:0] pc);
      logic [DATA_WIDTH-1:0] nxt;
      nxt = pc + DATA_WIDTH'(4);
      return (nxt >= PC_LIMIT) ? '0 : nxt;
   endfunction

   // Target is a word index; wider-than-memory targets fold back modulo the depth.
   function automatic logic [DATA_WIDTH-1:0] target_addr(input logic [11:0] tgt);
      logic [DATA_WIDTH-1:0] word;
      word = DATA_WIDTH'(tgt) % DATA_WIDTH'(MEM_DEPTH);
      return word << 2;
   endfunction

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_p0;
      ir_d     = ir_p1;
      ir_pc_d  = ir_pc_p1;
      vld_d    = vld_p1;
      free     = !vld_p1 || bus.IR_Ready;
      redirect = (state_q == RUN) && bus.Redirect_Valid;
      fetch    = (state_q == RUN) && !bus.Stall && free && !bus.Redirect_Valid;
      is_halt  = (bus.Mem_Instruction[DATA_WIDTH-1 -: 5] == HALT_OPCODE);

      if (vld_p1 && bus.IR_Ready) begin
         vld_d = 1'b0;
      end

      if (redirect) begin
         pc_d  = target_addr(bus.Redirect_Target);
         vld_d = 1'b0;
      end else if (fetch) begin
         ir_d    = bus.Mem_Instruction;
         ir_pc_d = pc_p0;
         vld_d   = 1'b1;
         // PC parks on the HALT word so Address keeps pointing at it.
         if (is_halt) begin
            state_d = HALTED;
         end else begin
            pc_d = wrap_inc(pc_p0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- p0 -> p1: PC and fetch register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p0    <= PC_RESET;
         ir_p1    <= '0;
         ir_pc_p1 <= '0;
         vld_p1   <= 1'b0;
      end else begin
         pc_p0    <= pc_d;
         ir_p1    <= ir_d;
         ir_pc_p1 <= ir_pc_d;
         vld_p1   <= vld_d;
      end
   end

   assign bus.Address  = pc_p0;
   assign bus.IR       = ir_p1;
   assign bus.IR_PC    = ir_pc_p1;
   assign bus.IR_Valid = vld_p1;
   assign bus.Halted   = (state_q == HALTED);

`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0] fetch_cnt, stall_cnt;
   logic        blocked;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign blocked = (state_q == RUN) && !bus.Redirect_Valid && (bus.Stall || !free);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (fetch)   fetch_cnt <= sat_inc(fetch_cnt);
         if (blocked) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign bus.Fetch_Count = fetch_cnt;
   assign bus.Stall_Count = stall_cnt;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table for streaming/backpressure/redirect/wrap,
// hand sequences for HALT and mid-operation reset.
module tb_instruction_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

   instruction_fetch_unit #(.DATA_WIDTH(32), .MEM_DEPTH(256), .RESET_PC(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.Mem_Instruction = mem[bus.Address[9:2]];

   typedef struct {
      logic        stall;
      logic        rv;
      logic [11:0] tgt;
      logic        rdy;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] irpc;
      logic [31:0] ir;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(input logic stall, input logic rv, input logic [11:0] tgt, input logic rdy);
      bus.Stall           = stall;
      bus.Redirect_Valid  = rv;
      bus.Redirect_Target = tgt;
      bus.IR_Ready        = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] addr, input logic vld,
                              input logic [31:0] irpc, input logic halted);
      check({tag, " addr"},   bus.Address, addr);
      check({tag, " vld"},    32'(bus.IR_Valid), 32'(vld));
      check({tag, " irpc"},   bus.IR_PC, irpc);
      check({tag, " halted"}, 32'(bus.Halted), 32'(halted));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000 + 32'(i);

      vecs[0]  = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd4,    1'b1, 32'd0,    32'h0100_0000};
      vecs[1]  = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd8,    1'b1, 32'd4,    32'h0100_0001};
      vecs[2]  = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd12,   1'b1, 32'd8,    32'h0100_0002};
      vecs[3]  = '{1'b0, 1'b0, 12'd0,   1'b0, 32'd12,   1'b1, 32'd8,    32'h0100_0002};
      vecs[4]  = '{1'b0, 1'b0, 12'd0,   1'b0, 32'd12,   1'b1, 32'd8,    32'h0100_0002};
      vecs[5]  = '{1'b0, 1'b0, 12'd0,   1'b0, 32'd12,   1'b1, 32'd8,    32'h0100_0002};
      vecs[6]  = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd16,   1'b1, 32'd12,   32'h0100_0003};
      vecs[7]  = '{1'b1, 1'b0, 12'd0,   1'b0, 32'd16,   1'b1, 32'd12,   32'h0100_0003};
      vecs[8]  = '{1'b1, 1'b1, 12'd35,  1'b0, 32'd140,  1'b0, 32'd12,   32'h0100_0003};
      vecs[9]  = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd144,  1'b1, 32'd140,  32'h0100_0023};
      vecs[10] = '{1'b1, 1'b0, 12'd0,   1'b1, 32'd144,  1'b0, 32'd140,  32'h0100_0023};
      vecs[11] = '{1'b1, 1'b0, 12'd0,   1'b1, 32'd144,  1'b0, 32'd140,  32'h0100_0023};
      vecs[12] = '{1'b0, 1'b1, 12'd255, 1'b1, 32'd1020, 1'b0, 32'd140,  32'h0100_0023};
      vecs[13] = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd0,    1'b1, 32'd1020, 32'h0100_00FF};
      vecs[14] = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd4,    1'b1, 32'd0,    32'h0100_0000};
      vecs[15] = '{1'b0, 1'b1, 12'd260, 1'b1, 32'd16,   1'b0, 32'd0,    32'h0100_0000};
      vecs[16] = '{1'b0, 1'b0, 12'd0,   1'b1, 32'd20,   1'b1, 32'd16,   32'h0100_0004};

      // Reset state
      drive(1'b0, 1'b0, 12'd0, 1'b1);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_state("reset", 32'd0, 1'b0, 32'd0, 1'b0);
      check("reset ir", bus.IR, 32'd0);
`ifdef IFU_PERF_COUNTERS_EN
      check("reset fetch_cnt", bus.Fetch_Count, 32'd0);
      check("reset stall_cnt", bus.Stall_Count, 32'd0);
`endif

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].stall, vecs[i].rv, vecs[i].tgt, vecs[i].rdy);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].addr, vecs[i].vld, vecs[i].irpc, 1'b0);
         check($sformatf("vec%0d ir", i), bus.IR, vecs[i].ir);
      end

      // HALT at word 5
      mem[5] = 32'hF800_0000;
      drive(1'b0, 1'b0, 12'd0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_state("pre_halt", 32'd20, 1'b1, 32'd16, 1'b0);
      tick();
      check_state("halt", 32'd20, 1'b1, 32'd20, 1'b1);
      check("halt ir", bus.IR, 32'hF800_0000);
      drive(1'b0, 1'b1, 12'd35, 1'b0);
      tick();
      tick();
      check_state("halt_redirect", 32'd20, 1'b1, 32'd20, 1'b1);
      drive(1'b0, 1'b0, 12'd0, 1'b1);
      tick();
      check_state("halt_consume", 32'd20, 1'b0, 32'd20, 1'b1);
      tick();
      check_state("halt_idle", 32'd20, 1'b0, 32'd20, 1'b1);
`ifdef IFU_PERF_COUNTERS_EN
      check("halt fetch_cnt", bus.Fetch_Count, 32'd6);
      check("halt stall_cnt", bus.Stall_Count, 32'd0);
`endif

      // Reset out of HALTED, then reset again during backpressure at PC=48
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_state("unhalt", 32'd0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b1, 12'd11, 1'b0);
      tick();
      check_state("mid_redirect", 32'd44, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b0, 12'd0, 1'b0);
      tick();
      check_state("mid_fetch", 32'd48, 1'b1, 32'd44, 1'b0);
      check("mid_fetch ir", bus.IR, 32'h0100_000B);
      tick();
      check_state("mid_bp", 32'd48, 1'b1, 32'd44, 1'b0);
`ifdef IFU_PERF_COUNTERS_EN
      check("mid_bp fetch_cnt", bus.Fetch_Count, 32'd1);
      check("mid_bp stall_cnt", bus.Stall_Count, 32'd1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_state("mid_reset", 32'd0, 1'b0, 32'd0, 1'b0);
      check("mid_reset ir", bus.IR, 32'd0);
`ifdef IFU_PERF_COUNTERS_EN
      check("mid_reset fetch_cnt", bus.Fetch_Count, 32'd0);
      check("mid_reset stall_cnt", bus.Stall_Count, 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
